// File: rtl/inv_key_sched_pkg.sv
// Shared constants and types for the AES-128 inverse key schedule.
// Holds the FSM encoding, the round-constant table and the key geometry.
package inv_key_sched_pkg;

  localparam int KEY_W      = 128;
  localparam int NUM_ROUNDS = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  typedef logic [0:KEY_W-1] key_t;
  typedef logic [3:0]       round_t;

  // Entry i is Rcon for round i+1.
  localparam logic [7:0] RCON_TBL [NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] rcon_of(input round_t r);
    logic [7:0] rc;
    rc = 8'h00;
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (int'(r) == i + 1) rc = RCON_TBL[i];
    end
    return rc;
  endfunction

endpackage

// File: rtl/inv_key_sched_round.sv
// One inverse AES-128 key-expansion step: round key r -> round key r-1.
module inv_key_round
  import inv_key_sched_pkg::*;
(
  input  logic [0:KEY_W-1] key_in,
  input  logic [7:0]       rcon,
  output logic [0:KEY_W-1] key_out
);

  logic [0:31] w4, w5, w6, w7;
  logic [0:31] w0, w1, w2, w3;
  logic [0:31] rot_w3, sub_w3;

  assign w4 = key_in[0:31];
  assign w5 = key_in[32:63];
  assign w6 = key_in[64:95];
  assign w7 = key_in[96:127];

  assign w3 = w7 ^ w6;
  assign w2 = w6 ^ w5;
  assign w1 = w5 ^ w4;

  // RotWord: byte 0 of w3 moves to the last position.
  assign rot_w3 = {w3[8:31], w3[0:7]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    sbox u_sbox (
      .hi  (rot_w3[8*b +: 4]),
      .lo  (rot_w3[8*b+4 +: 4]),
      .sub (sub_w3[8*b +: 8])
    );
  end

  assign w0      = w4 ^ sub_w3 ^ {rcon, 24'h000000};
  assign key_out = {w0, w1, w2, w3};

endmodule

// File: rtl/sbox.sv
// AES forward S-box as a flat lookup; input split into high and low nibble.
module sbox (
  input  logic [3:0] hi,
  input  logic [3:0] lo,
  output logic [7:0] sub
);

  // Byte n of the table occupies bits [8n:8n+7], MSB first.
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_idx;

  assign bit_idx = {hi, lo, 3'b000};
  assign sub     = SBOX_TBL[bit_idx +: 8];

endmodule

// File: rtl/inv_key_sched.sv
// Walks the AES-128 key schedule backwards from the round-10 key, emitting
// one round key per accepted handshake, round 10 down to round 0.
module inv_key_sched
  import inv_key_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:KEY_W-1] last_key,
  output logic [0:KEY_W-1] key_out,
  output logic [3:0]       round_idx,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             busy,
  output logic             done,
  output logic [0:0]       dbg_state_o
);

  // Handshake: a key transfers on a rising edge where key_valid and key_ready
  // are both 1; key_out/round_idx hold steady while key_valid=1 and key_ready=0.

  logic [0:0]       state_q, state_d;
  logic [0:KEY_W-1] key_q, key_d;
  round_t           round_q, round_d;
  logic             done_q, done_d;
  logic [0:KEY_W-1] prev_key;
  logic             emit_xfer;

  inv_key_round u_round (
    .key_in  (key_q),
    .rcon    (rcon_of(round_q)),
    .key_out (prev_key)
  );

  assign emit_xfer = (state_q == ST_EMIT) && key_ready;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = last_key;
          round_d = round_t'(NUM_ROUNDS);
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (emit_xfer) begin
          if (round_q == 4'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = prev_key;
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign key_out     = key_q;
  assign round_idx   = round_q;
  assign key_valid   = (state_q == ST_EMIT);
  assign busy        = (state_q == ST_EMIT);
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inv_key_sched.sv
// Bench for inv_key_sched: forward-schedule model feeds an expected queue that
// a negedge monitor drains on every handshake.
module tb_inv_key_sched;

  logic         clk;
  logic         rst;
  logic         start;
  logic [0:127] last_key;
  logic [0:127] key_out;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;
  logic [0:0]   dbg_state_o;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int start_cyc;

  logic [131:0] exp_q[$];
  logic [131:0] exp_e;
  logic [127:0] obs_key [0:10];
  logic         have_prev = 1'b0;
  logic [127:0] prev_key;
  logic [3:0]   prev_round;

  localparam logic [127:0] FIPS_CK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_LK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;

  inv_key_sched dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .last_key    (last_key),
    .key_out     (key_out),
    .round_idx   (round_idx),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    if (a != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(a, 8'(y)) == 8'h01) inv = 8'(y);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
  endfunction

  // Forward-expand the cipher key, queue rounds 10..0, return the round-10 key.
  task automatic push_sched(input logic [127:0] ck, output logic [127:0] lk);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    w[0] = ck[127:96]; w[1] = ck[95:64]; w[2] = ck[63:32]; w[3] = ck[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 10; r >= 0; r--) begin
      exp_q.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
    end
    lk = {w[40], w[41], w[42], w[43]};
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (key_valid === 1'b1) begin
      if (have_prev) begin
        n_checks++;
        if (key_out !== prev_key || round_idx !== prev_round) begin
          n_bad++;
          $display("FAIL stall_stable: got round=%0d key=%h, want round=%0d key=%h",
                   round_idx, key_out, prev_round, prev_key);
        end
      end
      if (key_ready === 1'b1) begin
        have_prev = 1'b0;
        if (round_idx <= 4'd10) obs_key[round_idx] = key_out;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_key: got round=%0d key=%h, want no transfer", round_idx, key_out);
        end else begin
          exp_e = exp_q.pop_front();
          if ({round_idx, key_out} !== exp_e) begin
            n_bad++;
            $display("FAIL key_seq: got round=%0d key=%h, want round=%0d key=%h",
                     round_idx, key_out, exp_e[131:128], exp_e[127:0]);
          end
        end
      end else begin
        have_prev  = 1'b1;
        prev_key   = key_out;
        prev_round = round_idx;
      end
    end else begin
      have_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_sched(input logic [127:0] lk);
    @(posedge clk); #1;
    start     = 1'b1;
    last_key  = lk;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int dcyc, output bit ok);
    ok = 1'b0;
    dcyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (!ok) begin
        @(posedge clk); #1;
        if (done === 1'b1) begin
          ok = 1'b1;
          dcyc = cyc;
        end
      end
    end
    n_checks++;
    if (!ok) begin
      n_bad++;
      $display("FAIL done_timeout: got no done within 200 cycles, want done pulse");
    end
  endtask

  task automatic wait_round(input logic [3:0] r);
    int i;
    i = 0;
    while (!(key_valid === 1'b1 && round_idx === r) && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    n_checks++;
    if (i >= 100) begin
      n_bad++;
      $display("FAIL wait_round: got round=%0d, want round=%0d within 100 cycles", round_idx, r);
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drained: got %0d keys outstanding, want 0", name, exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; start = 1'b0; last_key = '0; key_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks += 6;
    if (key_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", key_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    if (round_idx !== 4'd0) begin n_bad++; $display("FAIL rst_round: got %0d want 0", round_idx); end
    if (key_out !== 128'h0) begin n_bad++; $display("FAIL rst_key: got %h want 0", key_out); end
    if (dbg_state_o !== 1'b0) begin n_bad++; $display("FAIL rst_state: got %b want 0", dbg_state_o); end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic test_fips();
    logic [127:0] lk;
    int dcyc;
    bit ok;
    key_ready = 1'b1;
    push_sched(FIPS_CK, lk);
    start_sched(lk);
    wait_done(dcyc, ok);
    n_checks += 4;
    if (dcyc != start_cyc + 12) begin n_bad++; $display("FAIL fips_done_cycle: got %0d want %0d", dcyc, start_cyc + 12); end
    if (obs_key[10] !== FIPS_LK) begin n_bad++; $display("FAIL fips_r10: got %h want %h", obs_key[10], FIPS_LK); end
    if (obs_key[9] !== FIPS_R9) begin n_bad++; $display("FAIL fips_r9: got %h want %h", obs_key[9], FIPS_R9); end
    if (obs_key[0] !== FIPS_CK) begin n_bad++; $display("FAIL fips_r0: got %h want %h", obs_key[0], FIPS_CK); end
    @(posedge clk); #1;
    n_checks += 2;
    if (done !== 1'b0) begin n_bad++; $display("FAIL fips_done_width: got %b want 0", done); end
    if (key_valid !== 1'b0) begin n_bad++; $display("FAIL fips_idle_valid: got %b want 0", key_valid); end
    check_drained("fips");
  endtask

  task automatic test_zero_key();
    logic [127:0] lk;
    int dcyc;
    bit ok;
    key_ready = 1'b1;
    push_sched(128'h0, lk);
    start_sched(lk);
    wait_done(dcyc, ok);
    n_checks++;
    if (obs_key[0] !== 128'h0) begin n_bad++; $display("FAIL zero_r0: got %h want 0", obs_key[0]); end
    check_drained("zero");
  endtask

  task automatic test_stall();
    logic [127:0] lk;
    int  stall_n;
    bit  fin;
    stall_n = 0;
    fin = 1'b0;
    key_ready = 1'b1;
    push_sched(FIPS_CK, lk);
    start_sched(lk);
    for (int i = 0; i < 600; i++) begin
      if (!fin) begin
        @(posedge clk); #1;
        if (done === 1'b1) fin = 1'b1;
        else if (key_valid === 1'b1 && round_idx === 4'd5 && stall_n < 20) begin
          key_ready = 1'b0;
          stall_n++;
        end else key_ready = 1'($urandom_range(0, 1));
      end
    end
    key_ready = 1'b1;
    n_checks += 2;
    if (!fin) begin n_bad++; $display("FAIL stall_done: got no done in 600 cycles, want done"); end
    if (stall_n != 20) begin n_bad++; $display("FAIL stall_len: got %0d stalled cycles want 20", stall_n); end
    check_drained("stall");
  endtask

  task automatic test_start_ignored();
    logic [127:0] lk, other_lk, tmp;
    int dcyc;
    bit ok;
    key_ready = 1'b1;
    push_sched(128'h000102030405060708090a0b0c0d0e0f, other_lk);
    exp_q.delete();
    push_sched(FIPS_CK, lk);
    start_sched(lk);
    wait_round(4'd7);
    start = 1'b1;
    last_key = other_lk;
    @(posedge clk); #1;
    start = 1'b0;
    tmp = lk;
    wait_done(dcyc, ok);
    @(posedge clk); #1;
    n_checks += 2;
    if (key_valid !== 1'b0) begin n_bad++; $display("FAIL ign_valid: got %b want 0", key_valid); end
    if (obs_key[0] !== FIPS_CK) begin n_bad++; $display("FAIL ign_r0: got %h want %h", obs_key[0], FIPS_CK); end
    check_drained("ignore");
  endtask

  task automatic test_reset_mid();
    logic [127:0] lk;
    int dcnt, dcyc;
    bit ok;
    key_ready = 1'b1;
    push_sched(FIPS_CK, lk);
    start_sched(lk);
    wait_round(4'd4);
    dcnt = done_cnt;
    #1 rst = 1'b1;
    #1;
    n_checks += 4;
    if (key_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", key_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (round_idx !== 4'd0) begin n_bad++; $display("FAIL midrst_round: got %0d want 0", round_idx); end
    if (key_out !== 128'h0) begin n_bad++; $display("FAIL midrst_key: got %h want 0", key_out); end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != dcnt) begin n_bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - dcnt); end
    push_sched(128'h0, lk);
    start_sched(lk);
    wait_done(dcyc, ok);
    check_drained("midrst");
  endtask

  task automatic test_back_to_back();
    logic [127:0] lk_a, lk_b;
    int dcyc;
    bit ok;
    key_ready = 1'b1;
    push_sched(128'h0, lk_a);
    start_sched(lk_a);
    wait_done(dcyc, ok);
    push_sched(FIPS_CK, lk_b);
    start = 1'b1;
    last_key = lk_b;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks += 3;
    if (key_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", key_valid); end
    if (round_idx !== 4'd10) begin n_bad++; $display("FAIL b2b_round: got %0d want 10", round_idx); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
    wait_done(dcyc, ok);
    check_drained("b2b");
  endtask

  initial begin
    test_reset();
    test_fips();
    test_zero_key();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
